spi_byte_master: RTL

- Byte-level SPI master (mode 0, MSB first) that serialises command/data bytes from the SD-card command sequencer onto MOSI/SCLK.
- Returns the byte shifted in on MISO during the same transfer.
- Sits directly downstream of the card driver, which feeds it through the W_* handshake and consumes the R_* result.
- Does not drive CS; chip select stays with the card driver.

---
 rtl/spi_byte_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_byte_master.sv
// Byte-wide SPI master, mode 0, MSB first; MISO byte returned through the R_* handshake.
// Build option SPI_LOOPBACK_EN adds a LOOPBACK input that routes MOSI back into the receive shifter.
module spi_byte_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       CLOCK50,
  input  logic       RESET,
  input  logic       W_STB,
  input  logic [7:0] W_DATA,
  output logic       W_ACK,
  output logic       R_STB,
  output logic [7:0] R_DATA,
  input  logic       R_ACK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SCLK,
  output logic       BUSY
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic       LOOPBACK
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic       w_ack_q, w_ack_d;
  logic       r_stb_q, r_stb_d;
  logic [7:0] r_data_q, r_data_d;
  logic       mosi_q, mosi_d;
  logic       sclk_q, sclk_d;
  logic       busy_q, busy_d;
  logic       accept_s;
  logic       div_zero_s;
  logic       sample_bit_s;

  // An unread result blocks new requests unless it is being acknowledged this cycle.
  assign accept_s   = (state_q == S_IDLE) && W_STB && (!r_stb_q || R_ACK);
  assign div_zero_s = (div_cnt_q == 8'd0);

`ifdef SPI_LOOPBACK_EN
  logic lb_q, lb_d;
  assign sample_bit_s = lb_q ? mosi_q : MISO;
`else
  assign sample_bit_s = MISO;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLOCK50) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      tx_shift_q <= 7'd0;
      rx_shift_q <= 8'd0;
      bit_cnt_q  <= 3'd0;
      div_cnt_q  <= 8'd0;
      w_ack_q    <= 1'b0;
      r_stb_q    <= 1'b0;
      r_data_q   <= 8'h00;
      mosi_q     <= 1'b1;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      w_ack_q    <= w_ack_d;
      r_stb_q    <= r_stb_d;
      r_data_q   <= r_data_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
`ifdef SPI_LOOPBACK_EN
      lb_q       <= lb_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_s) state_d = S_LOW; else state_d = S_IDLE;
      S_LOW:  if (div_zero_s) state_d = S_HIGH; else state_d = S_LOW;
      S_HIGH: begin
        if (div_zero_s) begin
          if (bit_cnt_q == 3'd7) state_d = S_DONE; else state_d = S_LOW;
        end else begin
          state_d = S_HIGH;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    r_data_d   = r_data_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    w_ack_d    = 1'b0;
    busy_d     = (state_d != S_IDLE);
`ifdef SPI_LOOPBACK_EN
    lb_d       = lb_q;
`endif
    if (r_stb_q && R_ACK) r_stb_d = 1'b0; else r_stb_d = r_stb_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          tx_shift_d = W_DATA[6:0];
          mosi_d     = W_DATA[7];
          bit_cnt_d  = 3'd0;
          div_cnt_d  = DIV_RELOAD;
          w_ack_d    = 1'b1;
`ifdef SPI_LOOPBACK_EN
          lb_d       = LOOPBACK;
`endif
        end else begin
          w_ack_d = 1'b0;
        end
      end
      S_LOW: begin
        if (div_zero_s) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], sample_bit_s};
          div_cnt_d  = DIV_RELOAD;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (div_zero_s) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = bit_cnt_q;
          end else begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            mosi_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
            div_cnt_d  = DIV_RELOAD;
          end
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        r_data_d = rx_shift_q;
        r_stb_d  = 1'b1;
        mosi_d   = 1'b1;
      end
      default: begin
        sclk_d = 1'b0;
        mosi_d = 1'b1;
      end
    endcase
  end

  assign W_ACK  = w_ack_q;
  assign R_STB  = r_stb_q;
  assign R_DATA = r_data_q;
  assign MOSI   = mosi_q;
  assign SCLK   = sclk_q;
  assign BUSY   = busy_q;

endmodule
